// File: rtl/video_dram_arb.sv
// Video / sprite / tilemap arbiter for a single DRAM issue slot.
// Optional build macro: VIDEO_ARB_RR_EN (round-robin ts/tm; default fixed ts priority).
module video_dram_arb (
    input  logic        clk,
    input  logic        res,
    input  logic        dram_slot,
    input  logic        video_go,
    input  logic [20:0] video_addr,
    input  logic [4:0]  video_bw,
    input  logic        ts_req,
    input  logic [20:0] ts_addr,
    input  logic        tm_req,
    input  logic [20:0] tm_addr,
    output logic        dram_req,
    output logic [20:0] dram_addr,
    output logic        video_pre_next,
    output logic        video_next,
    output logic        ts_pre_next,
    output logic        ts_next,
    output logic        tm_next,
    output logic        video_busy,
    output logic [1:0]  owner
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_VBURST = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VID  = 2'd1;
    localparam logic [1:0] OWN_TS   = 2'd2;
    localparam logic [1:0] OWN_TM   = 2'd3;

    logic [0:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [20:0] vaddr_q, vaddr_d;
    logic        ts_pend_q, ts_pend_d;
    logic        tm_pend_q, tm_pend_d;
    logic        req_q;
    logic [20:0] addr_q;
    logic [1:0]  own_q;
    logic [1:0]  p1_q, p2_q, p3_q;

    logic [1:0]  gnt;
    logic [20:0] gaddr;
    logic        ts_ok, tm_ok, pick_ts, go_ok;

    assign ts_ok = ts_req & ~ts_pend_q;
    assign tm_ok = tm_req & ~tm_pend_q;

`ifdef VIDEO_ARB_RR_EN
    logic rr_q;

    assign pick_ts = ~rr_q;

    // Round-robin pointer flips on every ts/tm grant; reset favours ts.
    always_ff @(posedge clk) begin
        if (!res) begin
            rr_q <= 1'b0;
        end else if (gnt == OWN_TS || gnt == OWN_TM) begin
            rr_q <= ~rr_q;
        end
    end
`else
    assign pick_ts = 1'b1;
`endif

    // Grant selection: video owns every slot during a burst.
    always_comb begin
        gnt   = OWN_NONE;
        gaddr = '0;
        if (dram_slot) begin
            if (state_q == S_VBURST) begin
                gnt   = OWN_VID;
                gaddr = vaddr_q;
            end else if (ts_ok && (!tm_ok || pick_ts)) begin
                gnt   = OWN_TS;
                gaddr = ts_addr;
            end else if (tm_ok) begin
                gnt   = OWN_TM;
                gaddr = tm_addr;
            end
        end
    end

    assign video_busy = (state_q == S_VBURST) || (p1_q == OWN_VID);
    assign go_ok      = video_go && (state_q == S_IDLE) && !video_busy;

    // Burst sequencing and per-requester outstanding masks.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        vaddr_d   = vaddr_q;
        ts_pend_d = ts_pend_q;
        tm_pend_d = tm_pend_q;
        if (state_q == S_IDLE) begin
            if (go_ok) begin
                state_d = S_VBURST;
                cnt_d   = video_bw;
                vaddr_d = video_addr;
            end
        end else if (gnt == OWN_VID) begin
            vaddr_d = vaddr_q + 21'd1;
            if (cnt_q == 5'd0) begin
                state_d = S_IDLE;
            end else begin
                cnt_d = cnt_q - 5'd1;
            end
        end
        if (gnt == OWN_TS) begin
            ts_pend_d = 1'b1;
        end else if (p3_q == OWN_TS) begin
            ts_pend_d = 1'b0;
        end
        if (gnt == OWN_TM) begin
            tm_pend_d = 1'b1;
        end else if (p3_q == OWN_TM) begin
            tm_pend_d = 1'b0;
        end
    end

    // State, issue register and 3-stage owner pipeline.
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            vaddr_q   <= '0;
            ts_pend_q <= 1'b0;
            tm_pend_q <= 1'b0;
            req_q     <= 1'b0;
            addr_q    <= '0;
            own_q     <= OWN_NONE;
            p1_q      <= OWN_NONE;
            p2_q      <= OWN_NONE;
            p3_q      <= OWN_NONE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            vaddr_q   <= vaddr_d;
            ts_pend_q <= ts_pend_d;
            tm_pend_q <= tm_pend_d;
            req_q     <= (gnt != OWN_NONE);
            if (gnt != OWN_NONE) begin
                addr_q <= gaddr;
                own_q  <= gnt;
            end
            p1_q <= gnt;
            p2_q <= p1_q;
            p3_q <= p2_q;
        end
    end

    assign dram_req       = req_q;
    assign dram_addr      = addr_q;
    assign owner          = own_q;
    assign video_pre_next = (p2_q == OWN_VID);
    assign ts_pre_next    = (p2_q == OWN_TS);
    assign video_next     = (p3_q == OWN_VID);
    assign ts_next        = (p3_q == OWN_TS);
    assign tm_next        = (p3_q == OWN_TM);

endmodule

// File: tb/tb_video_dram_arb.sv
// Directed bench for video_dram_arb.
// Honors VIDEO_ARB_RR_EN when choosing expected ts/tm order.
module tb_video_dram_arb;

    logic        clk;
    logic        res;
    logic        dram_slot;
    logic        video_go;
    logic [20:0] video_addr;
    logic [4:0]  video_bw;
    logic        ts_req;
    logic [20:0] ts_addr;
    logic        tm_req;
    logic [20:0] tm_addr;
    logic        dram_req;
    logic [20:0] dram_addr;
    logic        video_pre_next;
    logic        video_next;
    logic        ts_pre_next;
    logic        ts_next;
    logic        tm_next;
    logic        video_busy;
    logic [1:0]  owner;

    int total;
    int bad;
    int n_vpre, n_vnext, n_tspre, n_tsnext, n_tmnext;

    video_dram_arb dut (
        .clk            (clk),
        .res            (res),
        .dram_slot      (dram_slot),
        .video_go       (video_go),
        .video_addr     (video_addr),
        .video_bw       (video_bw),
        .ts_req         (ts_req),
        .ts_addr        (ts_addr),
        .tm_req         (tm_req),
        .tm_addr        (tm_addr),
        .dram_req       (dram_req),
        .dram_addr      (dram_addr),
        .video_pre_next (video_pre_next),
        .video_next     (video_next),
        .ts_pre_next    (ts_pre_next),
        .ts_next        (ts_next),
        .tm_next        (tm_next),
        .video_busy     (video_busy),
        .owner          (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (video_pre_next) n_vpre++;
        if (video_next) n_vnext++;
        if (ts_pre_next) n_tspre++;
        if (ts_next) n_tsnext++;
        if (tm_next) n_tmnext++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_vpre = 0; n_vnext = 0; n_tspre = 0; n_tsnext = 0; n_tmnext = 0;
    endtask

    task automatic do_reset();
        res = 1'b0;
        tick();
        res = 1'b1;
    endtask

    task automatic test_reset();
        res = 1'b0;
        tick();
        tick();
        total++;
        if (dram_req !== 1'b0 || dram_addr !== 21'h0) begin
            bad++;
            $display("FAIL reset_issue: req=%b addr=%h want 0/0", dram_req, dram_addr);
        end
        total++;
        if (owner !== 2'd0 || video_busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_owner: owner=%0d busy=%b want 0/0", owner, video_busy);
        end
        total++;
        if ({video_pre_next, video_next, ts_pre_next, ts_next, tm_next} !== 5'b0) begin
            bad++;
            $display("FAIL reset_strobes: got %b want 00000",
                {video_pre_next, video_next, ts_pre_next, ts_next, tm_next});
        end
        res = 1'b1;
        tick();
    endtask

    task automatic test_latency();
        do_reset();
        ts_addr = 21'h12345;
        ts_req = 1'b1;
        dram_slot = 1'b1;
        tick();
        dram_slot = 1'b0;
        total++;
        if (dram_req !== 1'b1 || dram_addr !== 21'h12345 || owner !== 2'd2) begin
            bad++;
            $display("FAIL lat_n1: req=%b addr=%h owner=%0d want 1/12345/2",
                dram_req, dram_addr, owner);
        end
        total++;
        if (ts_pre_next !== 1'b0 || ts_next !== 1'b0) begin
            bad++;
            $display("FAIL lat_n1_strobe: pre=%b next=%b want 0/0", ts_pre_next, ts_next);
        end
        tick();
        total++;
        if (dram_req !== 1'b0 || ts_pre_next !== 1'b1 || ts_next !== 1'b0) begin
            bad++;
            $display("FAIL lat_n2: req=%b pre=%b next=%b want 0/1/0",
                dram_req, ts_pre_next, ts_next);
        end
        tick();
        total++;
        if (ts_pre_next !== 1'b0 || ts_next !== 1'b1) begin
            bad++;
            $display("FAIL lat_n3: pre=%b next=%b want 0/1", ts_pre_next, ts_next);
        end
        ts_req = 1'b0;
        tick();
        total++;
        if (ts_next !== 1'b0 || dram_req !== 1'b0) begin
            bad++;
            $display("FAIL lat_n4: next=%b req=%b want 0/0", ts_next, dram_req);
        end
    endtask

    task automatic test_burst();
        logic [20:0] e;
        do_reset();
        clr_counts();
        video_addr = 21'h1FFFFE;
        video_bw = 5'd3;
        video_go = 1'b1;
        tick();
        video_go = 1'b0;
        total++;
        if (video_busy !== 1'b1) begin
            bad++;
            $display("FAIL burst_busy_start: busy=%b want 1", video_busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tick();
            tick();
            dram_slot = 1'b1;
            tick();
            dram_slot = 1'b0;
            e = 21'h1FFFFE + 21'(i);
            total++;
            if (dram_req !== 1'b1 || dram_addr !== e || owner !== 2'd1 || video_busy !== 1'b1) begin
                bad++;
                $display("FAIL burst_word%0d: req=%b addr=%h owner=%0d busy=%b want 1/%h/1/1",
                    i, dram_req, dram_addr, owner, video_busy, e);
            end
        end
        tick();
        total++;
        if (video_busy !== 1'b0 || dram_req !== 1'b0) begin
            bad++;
            $display("FAIL burst_end: busy=%b req=%b want 0/0", video_busy, dram_req);
        end
        dram_slot = 1'b1;
        tick();
        dram_slot = 1'b0;
        total++;
        if (dram_req !== 1'b0) begin
            bad++;
            $display("FAIL burst_idle_slot: req=%b want 0", dram_req);
        end
        tick();
        tick();
        tick();
        total++;
        if (n_vnext !== 4 || n_vpre !== 4) begin
            bad++;
            $display("FAIL burst_strobes: next=%0d pre=%0d want 4/4", n_vnext, n_vpre);
        end
    endtask

    task automatic test_busy_drop();
        do_reset();
        clr_counts();
        video_addr = 21'h000100;
        video_bw = 5'd1;
        video_go = 1'b1;
        tick();
        video_addr = 21'h000500;
        video_bw = 5'd7;
        tick();
        video_go = 1'b0;
        dram_slot = 1'b1;
        tick();
        total++;
        if (dram_req !== 1'b1 || dram_addr !== 21'h000100) begin
            bad++;
            $display("FAIL drop_w0: req=%b addr=%h want 1/000100", dram_req, dram_addr);
        end
        tick();
        total++;
        if (dram_req !== 1'b1 || dram_addr !== 21'h000101 || video_busy !== 1'b1) begin
            bad++;
            $display("FAIL drop_w1: req=%b addr=%h busy=%b want 1/000101/1",
                dram_req, dram_addr, video_busy);
        end
        tick();
        dram_slot = 1'b0;
        total++;
        if (dram_req !== 1'b0 || video_busy !== 1'b0) begin
            bad++;
            $display("FAIL drop_len: req=%b busy=%b want 0/0", dram_req, video_busy);
        end
        tick();
        tick();
        tick();
        total++;
        if (n_vnext !== 2) begin
            bad++;
            $display("FAIL drop_next: count=%0d want 2", n_vnext);
        end
    endtask

    task automatic test_priority();
        do_reset();
        ts_addr = 21'h0AAAAA;
        tm_addr = 21'h0BBBBB;
        ts_req = 1'b1;
        tm_req = 1'b1;
        video_addr = 21'h000040;
        video_bw = 5'd1;
        video_go = 1'b1;
        tick();
        video_go = 1'b0;
        dram_slot = 1'b1;
        tick();
        total++;
        if (owner !== 2'd1 || dram_addr !== 21'h000040) begin
            bad++;
            $display("FAIL prio_v0: owner=%0d addr=%h want 1/000040", owner, dram_addr);
        end
        tick();
        total++;
        if (owner !== 2'd1 || dram_addr !== 21'h000041) begin
            bad++;
            $display("FAIL prio_v1: owner=%0d addr=%h want 1/000041", owner, dram_addr);
        end
        tick();
        dram_slot = 1'b0;
        total++;
        if (dram_req !== 1'b1 || owner !== 2'd2 || dram_addr !== 21'h0AAAAA) begin
            bad++;
            $display("FAIL prio_ts: req=%b owner=%0d addr=%h want 1/2/0aaaaa",
                dram_req, owner, dram_addr);
        end
        ts_req = 1'b0;
        tm_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic test_fairness();
        logic       er [6];
        logic [1:0] eo [6];
        logic [1:0] es [3];
        er[0] = 1'b1; eo[0] = 2'd2;
        er[1] = 1'b1; eo[1] = 2'd3;
        er[2] = 1'b0; eo[2] = 2'd3;
        er[3] = 1'b0; eo[3] = 2'd3;
        er[4] = 1'b1; eo[4] = 2'd2;
        er[5] = 1'b1; eo[5] = 2'd3;
`ifdef VIDEO_ARB_RR_EN
        es[0] = 2'd2; es[1] = 2'd3; es[2] = 2'd2;
`else
        es[0] = 2'd2; es[1] = 2'd2; es[2] = 2'd2;
`endif
        do_reset();
        ts_addr = 21'h000111;
        tm_addr = 21'h000222;
        ts_req = 1'b1;
        tm_req = 1'b1;
        dram_slot = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            total++;
            if (dram_req !== er[k] || owner !== eo[k]) begin
                bad++;
                $display("FAIL fair_b2b%0d: req=%b owner=%0d want %b/%0d",
                    k, dram_req, owner, er[k], eo[k]);
            end
        end
        dram_slot = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            dram_slot = 1'b1;
            tick();
            dram_slot = 1'b0;
            total++;
            if (dram_req !== 1'b1 || owner !== es[k]) begin
                bad++;
                $display("FAIL fair_spaced%0d: req=%b owner=%0d want 1/%0d",
                    k, dram_req, owner, es[k]);
            end
            tick();
            tick();
            tick();
        end
        ts_req = 1'b0;
        tm_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_inflight();
        do_reset();
        ts_addr = 21'h000777;
        ts_req = 1'b1;
        dram_slot = 1'b1;
        tick();
        dram_slot = 1'b0;
        clr_counts();
        res = 1'b0;
        tick();
        total++;
        if (dram_req !== 1'b0 || owner !== 2'd0 || dram_addr !== 21'h0) begin
            bad++;
            $display("FAIL rst_fly_out: req=%b owner=%0d addr=%h want 0/0/0",
                dram_req, owner, dram_addr);
        end
        res = 1'b1;
        ts_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (n_tspre !== 0 || n_tsnext !== 0) begin
            bad++;
            $display("FAIL rst_fly_strobe: pre=%0d next=%0d want 0/0", n_tspre, n_tsnext);
        end
        video_addr = 21'h000300;
        video_bw = 5'd5;
        video_go = 1'b1;
        tick();
        video_go = 1'b0;
        dram_slot = 1'b1;
        tick();
        dram_slot = 1'b0;
        clr_counts();
        res = 1'b0;
        tick();
        res = 1'b1;
        total++;
        if (video_busy !== 1'b0 || dram_req !== 1'b0) begin
            bad++;
            $display("FAIL rst_burst: busy=%b req=%b want 0/0", video_busy, dram_req);
        end
        dram_slot = 1'b1;
        tick();
        dram_slot = 1'b0;
        total++;
        if (dram_req !== 1'b0) begin
            bad++;
            $display("FAIL rst_burst_idle: req=%b want 0", dram_req);
        end
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (n_vnext !== 0 || n_vpre !== 0) begin
            bad++;
            $display("FAIL rst_burst_strobe: next=%0d pre=%0d want 0/0", n_vnext, n_vpre);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        clr_counts();
        res = 1'b0;
        dram_slot = 1'b0;
        video_go = 1'b0;
        video_addr = '0;
        video_bw = '0;
        ts_req = 1'b0;
        ts_addr = '0;
        tm_req = 1'b0;
        tm_addr = '0;
        tick();
        test_reset();
        test_latency();
        test_burst();
        test_busy_drop();
        test_priority();
        test_fairness();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
